// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key controller: scan codes, FSM state
// encoding and the paddle direction type.
package ps2_pkg;

  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_LARROW = 8'h6B;
  localparam logic [7:0] SC_RARROW = 8'h74;

  localparam logic [7:0] SC_LVL1 = 8'h16;
  localparam logic [7:0] SC_LVL2 = 8'h1E;
  localparam logic [7:0] SC_LVL3 = 8'h26;
  localparam logic [7:0] SC_LVL4 = 8'h25;
  localparam logic [7:0] SC_LVL5 = 8'h2E;
  localparam logic [7:0] SC_LVL6 = 8'h36;
  localparam logic [7:0] SC_LVL7 = 8'h3D;
  localparam logic [7:0] SC_LVL8 = 8'h3E;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef enum logic {
    DIR_L = 1'b0,
    DIR_R = 1'b1
  } dir_e;

  // Map a digit scan code to its level (1..8); 0 means "not a level key".
  function automatic logic [3:0] level_of_code(input logic [7:0] code);
    logic [3:0] lvl;
    case (code)
      SC_LVL1: lvl = 4'd1;
      SC_LVL2: lvl = 4'd2;
      SC_LVL3: lvl = 4'd3;
      SC_LVL4: lvl = 4'd4;
      SC_LVL5: lvl = 4'd5;
      SC_LVL6: lvl = 4'd6;
      SC_LVL7: lvl = 4'd7;
      SC_LVL8: lvl = 4'd8;
      default: lvl = 4'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ps2_prefix_timer.sv
// Prefix follow-up timer. Held at zero while cleared, otherwise counts up
// and raises a one-cycle expiry at TIMEOUT_CYC-1, then restarts from zero.
// An active clear in the expiry cycle suppresses the expiry.
module ps2_prefix_timer #(
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_expire
);

  localparam int              W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] r_cnt;

  assign o_expire = !i_clr && (r_cnt == LAST);

  // Count while a prefix is pending; clear on reset, clear request or expiry.
  always_ff @(posedge clk) begin
    if (rst || i_clr || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 scan-code sequencer for the Breakout game: tracks F0/E0 prefixes,
// keeps per-key held flags and drives level select and paddle direction.
// Optional build macro ARROW_KEYS_EN adds E0-prefixed arrow keys as a second
// source for each paddle direction.
//
// state      | meaning
// -----------+--------------------------------------------
// ST_IDLE    | no prefix pending; next byte is a make code
// ST_BRK     | F0 seen; next byte is a break code
// ST_EXT     | E0 seen; next byte is extended make or F0
// ST_EXT_BRK | E0 F0 seen; next byte is an extended break
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 200000,
  parameter int DEFAULT_LEVEL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic [3:0] level,
  output logic       level_chg,
  output logic       left,
  output logic       right,
  output logic       frame_err,
  output logic       timeout
);

  localparam logic [3:0] LVL_RST = 4'(DEFAULT_LEVEL);

  ps2_state_e r_state, w_state_nxt;

  logic [3:0] r_level, w_level_nxt;
  logic       r_level_chg, w_level_chg_nxt;
  logic       r_left, w_left_nxt;
  logic       r_right, w_right_nxt;
  logic       r_frame_err, w_frame_err_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic       r_held_a, w_held_a_nxt;
  logic       r_held_d, w_held_d_nxt;
  dir_e       r_last_dir, w_last_dir_nxt;

  logic       w_do_make, w_do_brk, w_is_ext, w_is_prefix;
  logic       w_timer_clr, w_expire;
  logic       w_l_cur, w_r_cur, w_l_nxt, w_r_nxt;
  logic [3:0] w_code_lvl;

`ifdef ARROW_KEYS_EN
  logic r_held_la, w_held_la_nxt;
  logic r_held_ra, w_held_ra_nxt;
`endif

  assign w_is_prefix = (rx_data == SC_F0) || (rx_data == SC_E0);
  assign w_code_lvl  = level_of_code(rx_data);
  assign w_timer_clr = rx_valid || (r_state == ST_IDLE);

  ps2_prefix_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_timer_clr),
    .o_expire (w_expire)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus decode strobes; a received byte takes priority over expiry.
  always_comb begin
    w_state_nxt     = r_state;
    w_do_make       = 1'b0;
    w_do_brk        = 1'b0;
    w_is_ext        = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_timeout_nxt   = 1'b0;
    if (rx_valid) begin
      if (rx_err) begin
        w_state_nxt     = ST_IDLE;
        w_frame_err_nxt = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (rx_data == SC_F0) begin
              w_state_nxt = ST_BRK;
            end else if (rx_data == SC_E0) begin
              w_state_nxt = ST_EXT;
            end else begin
              w_do_make = 1'b1;
            end
          end
          ST_BRK: begin
            w_state_nxt = ST_IDLE;
            w_do_brk    = !w_is_prefix;
          end
          ST_EXT: begin
            if (rx_data == SC_F0) begin
              w_state_nxt = ST_EXT_BRK;
            end else begin
              w_state_nxt = ST_IDLE;
              w_do_make   = 1'b1;
              w_is_ext    = 1'b1;
            end
          end
          ST_EXT_BRK: begin
            w_state_nxt = ST_IDLE;
            w_do_brk    = !w_is_prefix;
            w_is_ext    = 1'b1;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end else if (w_expire) begin
      w_state_nxt   = ST_IDLE;
      w_timeout_nxt = 1'b1;
    end
  end

`ifdef ARROW_KEYS_EN
  assign w_l_cur = r_held_a | r_held_la;
  assign w_r_cur = r_held_d | r_held_ra;
  assign w_l_nxt = w_held_a_nxt | w_held_la_nxt;
  assign w_r_nxt = w_held_d_nxt | w_held_ra_nxt;
`else
  assign w_l_cur = r_held_a;
  assign w_r_cur = r_held_d;
  assign w_l_nxt = w_held_a_nxt;
  assign w_r_nxt = w_held_d_nxt;
`endif

  // Key decode: level select, held flags, last-pressed direction and resolution.
  always_comb begin
    w_level_nxt  = r_level;
    w_held_a_nxt = r_held_a;
    w_held_d_nxt = r_held_d;
`ifdef ARROW_KEYS_EN
    w_held_la_nxt = r_held_la;
    w_held_ra_nxt = r_held_ra;
`endif
    if (w_do_make && !w_is_ext) begin
      if (w_code_lvl != 4'd0) w_level_nxt = w_code_lvl;
      if (rx_data == SC_A) w_held_a_nxt = 1'b1;
      if (rx_data == SC_D) w_held_d_nxt = 1'b1;
    end
    if (w_do_brk && !w_is_ext) begin
      if (rx_data == SC_A) w_held_a_nxt = 1'b0;
      if (rx_data == SC_D) w_held_d_nxt = 1'b0;
    end
`ifdef ARROW_KEYS_EN
    if (w_do_make && w_is_ext) begin
      if (rx_data == SC_LARROW) w_held_la_nxt = 1'b1;
      if (rx_data == SC_RARROW) w_held_ra_nxt = 1'b1;
    end
    if (w_do_brk && w_is_ext) begin
      if (rx_data == SC_LARROW) w_held_la_nxt = 1'b0;
      if (rx_data == SC_RARROW) w_held_ra_nxt = 1'b0;
    end
`endif
    w_level_chg_nxt = (w_level_nxt != r_level);

    // Only a group going from released to held moves last_dir, so typematic
    // repeats and a second key in an already-held group leave it alone.
    w_last_dir_nxt = r_last_dir;
    if (!w_l_cur && w_l_nxt) begin
      w_last_dir_nxt = DIR_L;
    end else if (!w_r_cur && w_r_nxt) begin
      w_last_dir_nxt = DIR_R;
    end

    w_left_nxt  = w_l_nxt & (~w_r_nxt | (w_last_dir_nxt == DIR_L));
    w_right_nxt = w_r_nxt & (~w_l_nxt | (w_last_dir_nxt == DIR_R));
  end

  // Registered key state and game-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level     <= LVL_RST;
      r_level_chg <= 1'b0;
      r_left      <= 1'b0;
      r_right     <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_held_a    <= 1'b0;
      r_held_d    <= 1'b0;
      r_last_dir  <= DIR_L;
    end else begin
      r_level     <= w_level_nxt;
      r_level_chg <= w_level_chg_nxt;
      r_left      <= w_left_nxt;
      r_right     <= w_right_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_timeout   <= w_timeout_nxt;
      r_held_a    <= w_held_a_nxt;
      r_held_d    <= w_held_d_nxt;
      r_last_dir  <= w_last_dir_nxt;
    end
  end

`ifdef ARROW_KEYS_EN
  // Arrow-key held flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held_la <= 1'b0;
      r_held_ra <= 1'b0;
    end else begin
      r_held_la <= w_held_la_nxt;
      r_held_ra <= w_held_ra_nxt;
    end
  end
`endif

  assign level     = r_level;
  assign level_chg = r_level_chg;
  assign left      = r_left;
  assign right     = r_right;
  assign frame_err = r_frame_err;
  assign timeout   = r_timeout;

endmodule
